// File: rtl/div_seq_unit_if.sv
// div_seq_unit_if: start/busy/done handshake and operand/result bus for the byte divide unit.
interface div_seq_unit_if;
    logic        start;
    logic        signed_op;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_error;
    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_error
    );
    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_error
    );
endinterface

// File: rtl/div_seq_unit.sv
// div_seq_unit: multi-cycle 16/8 restoring DIV/IDIV with 8086 sign and divide-error semantics.
module div_seq_unit (
    input  logic        clk,
    input  logic        rst_n,
    div_seq_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [8:0]  p_q, p_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sop_q, sop_d, sq_q, sq_d, sr_q, sr_d;
    logic [7:0]  quo_q, quo_d, rem_q, rem_d;
    logic        err_q, err_d, busy_q, busy_d, done_q, done_d;
    logic [8:0]  p_sh;
    logic [9:0]  trial;
    logic        ovf;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        sop_d   = sop_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        p_sh    = {p_q[7:0], a_q[15]};
        trial   = {1'b0, p_sh} - {2'b00, dvs_q};
        // dvs_q stays zero through PREP on a zero divisor, so FIX can test it directly
        ovf     = (dvs_q == 8'd0) || (sop_q ? (a_q > 16'd127) : (a_q > 16'd255));
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = PREP;
                a_d     = bus.dividend;
                dvs_d   = bus.divisor;
                sop_d   = bus.signed_op;
            end
            PREP: if (dvs_q == 8'd0) state_d = FIX;
            else begin
                state_d = CALC;
                a_d     = (sop_q && a_q[15]) ? -a_q : a_q;
                dvs_d   = (sop_q && dvs_q[7]) ? -dvs_q : dvs_q;
                sq_d    = sop_q & (a_q[15] ^ dvs_q[7]);
                sr_d    = sop_q & a_q[15];
                p_d     = 9'd0;
                cnt_d   = 4'd0;
            end
            CALC: begin
                p_d   = trial[9] ? p_sh : trial[8:0];
                a_d   = {a_q[14:0], ~trial[9]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = FIX;
            end
            FIX: begin
                err_d   = ovf;
                quo_d   = ovf ? quo_q : (sq_q ? -a_q[7:0] : a_q[7:0]);
                rem_d   = ovf ? rem_q : (sr_q ? -p_q[7:0] : p_q[7:0]);
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == PREP) || (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            p_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sop_q   <= 1'b0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sop_q   <= sop_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.div_error = err_q;
endmodule
